pipe_issue_ctrl: RTL

//  Issue controller between the ID and EX stages. Holds each decoded instruction on the ID->EX
//  syn/ack handshake until its source operands are free of RAW hazards. Tracks pending

---
 rtl/pipe_issue_ctrl_pkg.sv | 33 +++
 rtl/pipe_issue_ctrl_scoreboard.sv | 69 ++++++
 rtl/pipe_issue_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared types and sizing for the ID->EX issue controller and its scoreboard.
package pipe_issue_ctrl_pkg;

    localparam int NREG         = 32;
    localparam int IDX_W        = 5;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 3;

    localparam logic [CNT_W-1:0] CNT_SAT      = '1;
    localparam logic [CNT_W-1:0] INFLIGHT_LIM = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] rd;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
        logic             use1;
        logic             use2;
        logic             wb_e;
    } id_instr_t;

    // x0 is hard-wired zero, so writes to it never need tracking.
    function automatic logic is_writer(input id_instr_t instr);
        return instr.wb_e && (instr.rd != '0);
    endfunction

endpackage

// File: rtl/pipe_issue_ctrl_scoreboard.sv
// Per-register pending-write counters plus a global in-flight writer count.
// Reads are of the registered counts only; a retire becomes visible the next cycle.
module pipe_issue_ctrl_scoreboard
    import pipe_issue_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc_e,
    input  logic [IDX_W-1:0] i_inc_idx,
    input  logic             i_dec_e,
    input  logic [IDX_W-1:0] i_dec_idx,
    input  logic [IDX_W-1:0] i_rs1_idx,
    input  logic [IDX_W-1:0] i_rs2_idx,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0] o_rs1_cnt,
    output logic [CNT_W-1:0] o_rs2_cnt,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic [CNT_W-1:0] o_inflight
);

    logic [NREG-1:0][CNT_W-1:0] w_pend;
    logic                       w_inc_ok;
    logic                       w_dec_ok;
    logic [CNT_W-1:0]           r_inflight;

    assign w_pend[0] = '0;
    assign w_inc_ok  = i_inc_e && (i_inc_idx != '0);
    // A retire against an idle counter is dropped so nothing can underflow.
    assign w_dec_ok  = i_dec_e && (i_dec_idx != '0) && (w_pend[i_dec_idx] != '0);

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc_hit;
            logic             w_dec_hit;

            assign w_inc_hit = w_inc_ok && (i_inc_idx == IDX_W'(gi));
            assign w_dec_hit = w_dec_ok && (i_dec_idx == IDX_W'(gi));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_cnt <= '0;
                end else if (w_inc_hit && !w_dec_hit) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec_hit && !w_inc_hit) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_pend[gi] = r_cnt;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_inflight <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (w_dec_ok && !w_inc_ok) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign o_rs1_cnt  = w_pend[i_rs1_idx];
    assign o_rs2_cnt  = w_pend[i_rs2_idx];
    assign o_rd_cnt   = w_pend[i_rd_idx];
    assign o_inflight = r_inflight;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// ID->EX issue controller: holds a decoded instruction on the four-phase
// handshake until its operands are RAW-hazard free, with flush-discard support.
module pipe_issue_ctrl
    import pipe_issue_ctrl_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_syn,
    output logic             o_id_ack,
    input  logic [IDX_W-1:0] i_id_rd,
    input  logic [IDX_W-1:0] i_id_rs1,
    input  logic [IDX_W-1:0] i_id_rs2,
    input  logic             i_id_use1,
    input  logic             i_id_use2,
    input  logic             i_id_wb_e,
    output logic             o_ex_syn,
    input  logic             i_ex_ack,
    input  logic             i_wb_valid,
    input  logic [IDX_W-1:0] i_wb_rd,
    input  logic             i_flush,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_inflight
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_id_ack;
    logic             r_ex_syn;
    logic             r_stall;
    logic             w_id_ack_next;
    logic             w_ex_syn_next;
    logic             w_stall_next;
    id_instr_t        w_instr;
    logic             w_writer;
    logic             w_hazard;
    logic             w_issue;
    logic [CNT_W-1:0] w_rs1_cnt;
    logic [CNT_W-1:0] w_rs2_cnt;
    logic [CNT_W-1:0] w_rd_cnt;
    logic [CNT_W-1:0] w_inflight;

    assign w_instr = '{rd: i_id_rd, rs1: i_id_rs1, rs2: i_id_rs2,
                       use1: i_id_use1, use2: i_id_use2, wb_e: i_id_wb_e};
    assign w_writer = is_writer(w_instr);

    pipe_issue_ctrl_scoreboard u_sb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_inc_e    (w_issue && w_writer),
        .i_inc_idx  (i_id_rd),
        .i_dec_e    (i_wb_valid),
        .i_dec_idx  (i_wb_rd),
        .i_rs1_idx  (i_id_rs1),
        .i_rs2_idx  (i_id_rs2),
        .i_rd_idx   (i_id_rd),
        .o_rs1_cnt  (w_rs1_cnt),
        .o_rs2_cnt  (w_rs2_cnt),
        .o_rd_cnt   (w_rd_cnt),
        .o_inflight (w_inflight)
    );

    // Pend counters of x0 read as zero, so the rs!=0 terms fall out naturally.
    assign w_hazard = (i_id_use1 && (w_rs1_cnt != '0))
                    | (i_id_use2 && (w_rs2_cnt != '0))
                    | (w_writer && (w_rd_cnt == CNT_SAT))
                    | (w_writer && (w_inflight == INFLIGHT_LIM));

    assign w_issue = (r_state == ST_CHECK) && !i_flush && !w_hazard;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_id_ack <= 1'b0;
            r_ex_syn <= 1'b0;
            r_stall  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_id_ack <= w_id_ack_next;
            r_ex_syn <= w_ex_syn_next;
            r_stall  <= w_stall_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_id_syn) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (i_flush)        w_state_next = ST_DONE;
                else if (!w_hazard) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: if (i_ex_ack) w_state_next = ST_DONE;
            ST_DONE:  if (!i_id_syn && !i_ex_ack) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_id_ack_next = r_id_ack;
        w_ex_syn_next = r_ex_syn;
        w_stall_next  = 1'b0;
        case (r_state)
            ST_CHECK: begin
                if (i_flush)        w_id_ack_next = 1'b1;
                else if (!w_hazard) w_ex_syn_next = 1'b1;
                else                w_stall_next  = 1'b1;
            end
            ST_ISSUE: begin
                if (i_ex_ack) begin
                    w_ex_syn_next = 1'b0;
                    w_id_ack_next = 1'b1;
                end
            end
            ST_DONE:  if (!i_id_syn && !i_ex_ack) w_id_ack_next = 1'b0;
            default:  ;
        endcase
    end

    assign o_id_ack   = r_id_ack;
    assign o_ex_syn   = r_ex_syn;
    assign o_stall    = r_stall;
    assign o_inflight = w_inflight;

endmodule
